// File: rtl/pcpi_arbiter.sv
// PCPI arbiter: broadcasts a core PCPI request to NUM_CP coprocessors, locks onto the first claimant
// and returns its result as one registered pulse. Optional busy watchdog under PCPI_ARB_TIMEOUT_EN.
module pcpi_arbiter #(
   parameter int NUM_CP    = 2,
   parameter int OWNER_W   = 1,
   parameter int CLAIM_WIN = 15,
   parameter int MAX_BUSY  = 64
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  pcpi_valid,
   input  logic [31:0]           pcpi_insn,
   input  logic [31:0]           pcpi_rs1,
   input  logic [31:0]           pcpi_rs2,
   output logic                  pcpi_wr,
   output logic [31:0]           pcpi_rd,
   output logic                  pcpi_wait,
   output logic                  pcpi_ready,
   output logic [NUM_CP-1:0]     cp_valid,
   output logic [31:0]           cp_insn,
   output logic [31:0]           cp_rs1,
   output logic [31:0]           cp_rs2,
   input  logic [NUM_CP-1:0]     cp_wr,
   input  logic [NUM_CP*32-1:0]  cp_rd,
   input  logic [NUM_CP-1:0]     cp_wait,
   input  logic [NUM_CP-1:0]     cp_ready,
   output logic                  busy,
   output logic [OWNER_W-1:0]    owner,
   output logic                  timeout_pulse
);

   localparam int CNT_MAX = (MAX_BUSY > CLAIM_WIN) ? MAX_BUSY : CLAIM_WIN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_BCAST   = 3'd1,
      S_OWNED   = 3'd2,
      S_DONE    = 3'd3,
      S_NOCLAIM = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_CP-1:0]   cp_valid_q, cp_valid_d;
   logic [31:0]         insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [OWNER_W-1:0]  owner_q, owner_d;
   logic                wait_q, wait_d, ready_q, ready_d, wr_q, wr_d, tmo_q, tmo_d;
   logic [31:0]         rd_q, rd_d;

   logic                claim_any_s, win_ready_s, win_wr_s, own_ready_s, own_wr_s;
   logic [OWNER_W-1:0]  win_idx_s;
   logic [31:0]         win_rd_s, own_rd_s;

   // Claim priority (descending scan so the lowest index wins) and owner result mux
   always_comb begin
      claim_any_s = 1'b0;
      win_idx_s   = '0;
      win_ready_s = 1'b0;
      win_wr_s    = 1'b0;
      win_rd_s    = 32'h0;
      own_ready_s = 1'b0;
      own_wr_s    = 1'b0;
      own_rd_s    = 32'h0;
      for (int i = NUM_CP - 1; i >= 0; i--) begin
         if (cp_wait[i] || cp_ready[i]) begin
            claim_any_s = 1'b1;
            win_idx_s   = OWNER_W'(i);
            win_ready_s = cp_ready[i];
            win_wr_s    = cp_wr[i];
            win_rd_s    = cp_rd[32*i +: 32];
         end else begin
            claim_any_s = claim_any_s;
         end
         if (OWNER_W'(i) == owner_q) begin
            own_ready_s = cp_ready[i];
            own_wr_s    = cp_wr[i];
            own_rd_s    = cp_rd[32*i +: 32];
         end else begin
            own_ready_s = own_ready_s;
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cp_valid_d = cp_valid_q;
      insn_d     = insn_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      owner_d    = owner_q;
      wait_d     = wait_q;
      ready_d    = 1'b0;
      wr_d       = 1'b0;
      rd_d       = rd_q;
      tmo_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pcpi_valid) begin
               insn_d     = pcpi_insn;
               rs1_d      = pcpi_rs1;
               rs2_d      = pcpi_rs2;
               cp_valid_d = '1;
               cnt_d      = '0;
               state_d    = S_BCAST;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BCAST: begin
            if (!pcpi_valid) begin
               cp_valid_d = '0;
               state_d    = S_IDLE;
            end else if (claim_any_s) begin
               owner_d = win_idx_s;
               cnt_d   = '0;
               if (win_ready_s) begin
                  ready_d    = 1'b1;
                  wr_d       = win_wr_s;
                  rd_d       = win_rd_s;
                  cp_valid_d = '0;
                  state_d    = S_DONE;
               end else begin
                  cp_valid_d = NUM_CP'(1) << win_idx_s;
                  wait_d     = 1'b1;
                  state_d    = S_OWNED;
               end
            end else if (cnt_q == CNT_W'(CLAIM_WIN - 1)) begin
               cp_valid_d = '0;
               state_d    = S_NOCLAIM;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_OWNED: begin
            if (!pcpi_valid) begin
               cp_valid_d = '0;
               wait_d     = 1'b0;
               state_d    = S_IDLE;
            end else if (own_ready_s) begin
               ready_d    = 1'b1;
               wr_d       = own_wr_s;
               rd_d       = own_rd_s;
               wait_d     = 1'b0;
               cp_valid_d = '0;
               state_d    = S_DONE;
`ifdef PCPI_ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(MAX_BUSY - 1)) begin
               ready_d    = 1'b1;
               rd_d       = 32'h0;
               tmo_d      = 1'b1;
               wait_d     = 1'b0;
               cp_valid_d = '0;
               state_d    = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`else
            end else begin
               state_d = S_OWNED;
            end
`endif
         end
         S_DONE, S_NOCLAIM: begin
            if (!pcpi_valid) begin
               state_d = S_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            cp_valid_d = '0;
            wait_d     = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cp_valid_q <= '0;
         insn_q     <= 32'h0;
         rs1_q      <= 32'h0;
         rs2_q      <= 32'h0;
         owner_q    <= '0;
         wait_q     <= 1'b0;
         ready_q    <= 1'b0;
         wr_q       <= 1'b0;
         rd_q       <= 32'h0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cp_valid_q <= cp_valid_d;
         insn_q     <= insn_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         owner_q    <= owner_d;
         wait_q     <= wait_d;
         ready_q    <= ready_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         tmo_q      <= tmo_d;
      end
   end

   assign cp_valid      = cp_valid_q;
   assign cp_insn       = insn_q;
   assign cp_rs1        = rs1_q;
   assign cp_rs2        = rs2_q;
   assign owner         = owner_q;
   assign pcpi_wait     = wait_q;
   assign pcpi_ready    = ready_q;
   assign pcpi_wr       = wr_q;
   assign pcpi_rd       = rd_q;
   assign busy          = (state_q != S_IDLE);
   assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_pcpi_arbiter.sv
// Directed self-checking bench for pcpi_arbiter with a result scoreboard.
module tb_pcpi_arbiter;
   localparam int NUM_CP = 2;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic                 pcpi_valid;
   logic [31:0]          pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic                 pcpi_wr, pcpi_wait, pcpi_ready;
   logic [31:0]          pcpi_rd;
   logic [NUM_CP-1:0]    cp_valid;
   logic [31:0]          cp_insn, cp_rs1, cp_rs2;
   logic [NUM_CP-1:0]    cp_wr, cp_wait, cp_ready;
   logic [NUM_CP*32-1:0] cp_rd;
   logic                 busy;
   logic [0:0]           owner;
   logic                 timeout_pulse;

   int checks = 0;
   int failures = 0;
   logic [32:0] sb[$];

   pcpi_arbiter #(.NUM_CP(NUM_CP), .OWNER_W(1), .CLAIM_WIN(15), .MAX_BUSY(64)) dut (
      .clk(clk), .resetn(resetn),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
      .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
      .cp_valid(cp_valid), .cp_insn(cp_insn), .cp_rs1(cp_rs1), .cp_rs2(cp_rs2),
      .cp_wr(cp_wr), .cp_rd(cp_rd), .cp_wait(cp_wait), .cp_ready(cp_ready),
      .busy(busy), .owner(owner), .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait up to budget negedges for pcpi_ready, then compare against the oldest expectation.
   task automatic expect_ready(input string tag, input int budget);
      logic got;
      logic [32:0] e;
      got = 1'b0;
      for (int n = 0; n < budget && !got; n++) begin
         @(negedge clk);
         if (pcpi_ready) got = 1'b1;
      end
      chk({tag, "_ready"}, 64'(got), 64'(1));
      if (got) begin
         chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_wr"}, 64'(pcpi_wr), 64'(e[32]));
            chk({tag, "_rd"}, 64'(pcpi_rd), 64'(e[31:0]));
         end
      end
   endtask

   task automatic request(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = insn;
      pcpi_rs1   = a;
      pcpi_rs2   = b;
   endtask

   task automatic release_cp();
      cp_wait  = '0;
      cp_ready = '0;
      cp_wr    = '0;
      cp_rd    = '0;
   endtask

   task automatic end_request(input string tag);
      pcpi_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_idle"}, 64'(busy), 64'(0));
   endtask

   initial begin
      logic hit;
      int   hi, cyc;
      resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = 32'h0; pcpi_rs1 = 32'h0; pcpi_rs2 = 32'h0;
      release_cp();
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_cp_valid", 64'(cp_valid), 64'(0));
      chk("rst_ready", 64'({pcpi_ready, pcpi_wr, pcpi_wait, timeout_pulse}), 64'(0));
      chk("rst_rd", 64'(pcpi_rd), 64'(0));
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // mul a0,a0,a1: cp0 claims at once, ready four cycles later
      request(32'h02B50533, 32'h55, 32'h06);
      sb.push_back({1'b1, 32'h0000_01FE});
      @(negedge clk);
      chk("mul_bcast", 64'(cp_valid), 64'(2'b11));
      chk("mul_insn", 64'(cp_insn), 64'(32'h02B50533));
      chk("mul_ops", 64'({cp_rs1, cp_rs2}), {32'h55, 32'h06});
      cp_wait = 2'b01;
      @(negedge clk);
      chk("mul_wait", 64'(pcpi_wait), 64'(1));
      chk("mul_owner", 64'(owner), 64'(0));
      chk("mul_onehot", 64'(cp_valid), 64'(2'b01));
      repeat (3) @(negedge clk);
      cp_ready = 2'b01; cp_wr = 2'b01; cp_rd[31:0] = 32'h1FE;
      expect_ready("mul", 1);
      release_cp();
      @(negedge clk);
      chk("mul_pulse_end", 64'({pcpi_ready, pcpi_wr, pcpi_wait}), 64'(0));
      chk("mul_rd_hold", 64'(pcpi_rd), 64'(32'h1FE));
      chk("mul_done_busy", 64'(busy), 64'(1));
      end_request("mul");

      // Both claim together: cp0 wins, cp1 aborts
      request(32'h02B50533, 32'h0C, 32'h10);
      sb.push_back({1'b1, 32'h0000_00C0});
      @(negedge clk);
      cp_wait = 2'b11;
      @(negedge clk);
      chk("both_owner", 64'(owner), 64'(0));
      chk("both_onehot", 64'(cp_valid), 64'(2'b01));
      cp_wait = 2'b01;
      @(negedge clk);
      cp_ready = 2'b01; cp_wr = 2'b01; cp_rd[31:0] = 32'hC0;
      expect_ready("both", 1);
      release_cp();
      end_request("both");

      // No claim: broadcast held exactly CLAIM_WIN cycles
      request(32'h0000_000B, 32'h1, 32'h2);
      hi = 0; hit = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (cp_valid == 2'b11) hi++;
         if (pcpi_wait || pcpi_ready) hit = 1'b1;
      end
      chk("noclaim_window", 64'(hi), 64'(15));
      chk("noclaim_quiet", 64'(hit), 64'(0));
      chk("noclaim_busy", 64'(busy), 64'(1));
      end_request("noclaim");

      // Simultaneous ready in the first cycle: 2-cycle latency, lowest index wins
      request(32'h02B50533, 32'h3, 32'h4);
      sb.push_back({1'b1, 32'h0000_AAAA});
      @(negedge clk);
      cp_ready = 2'b11; cp_wr = 2'b11; cp_rd = {32'h0000_BBBB, 32'h0000_AAAA};
      expect_ready("simul", 1);
      chk("simul_owner", 64'(owner), 64'(0));
      chk("simul_nowait", 64'(pcpi_wait), 64'(0));
      release_cp();
      end_request("simul");

      // Core drops valid while OWNED: abort without pcpi_ready
      request(32'h02B50533, 32'h7, 32'h8);
      @(negedge clk);
      cp_wait = 2'b01;
      @(negedge clk);
      chk("abort_owned", 64'(pcpi_wait), 64'(1));
      pcpi_valid = 1'b0;
      @(negedge clk);
      chk("abort_idle", 64'({busy, cp_valid, pcpi_wait, pcpi_ready}), 64'(0));
      release_cp();

      // Asynchronous reset while OWNED
      request(32'h02B50533, 32'h9, 32'hA);
      @(negedge clk);
      cp_wait = 2'b01;
      @(negedge clk);
      chk("arst_pre", 64'(busy), 64'(1));
      #2 resetn = 1'b0;
      #1;
      chk("arst_ctrl", 64'({busy, cp_valid, pcpi_wait, pcpi_ready, pcpi_wr, owner, timeout_pulse}), 64'(0));
      chk("arst_data", 64'({pcpi_rd, cp_insn}), 64'(0));
      chk("arst_ops", 64'({cp_rs1, cp_rs2}), 64'(0));
      pcpi_valid = 1'b0;
      release_cp();
      @(negedge clk);
      resetn = 1'b1;

      // Only cp1 claims after reset
      request(32'h02B50533, 32'h11, 32'h22);
      sb.push_back({1'b1, 32'h1234_5678});
      @(negedge clk);
      cp_wait = 2'b10;
      @(negedge clk);
      chk("cp1_owner", 64'(owner), 64'(1));
      chk("cp1_valid0_low", 64'(cp_valid), 64'(2'b10));
      @(negedge clk);
      cp_ready = 2'b10; cp_wr = 2'b10; cp_rd[63:32] = 32'h1234_5678;
      expect_ready("cp1", 1);
      release_cp();
      end_request("cp1");

      // Owner never returns ready
      request(32'h02B50533, 32'h5, 32'h5);
      @(negedge clk);
      cp_wait = 2'b01;
      @(negedge clk);
      chk("stall_owned", 64'(pcpi_wait), 64'(1));
`ifdef PCPI_ARB_TIMEOUT_EN
      sb.push_back({1'b0, 32'h0});
      cyc = 0; hit = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
         @(negedge clk);
         cyc++;
         if (pcpi_ready) hit = 1'b1;
      end
      chk("tmo_cycles", 64'(cyc), 64'(64));
      chk("tmo_pulse", 64'(timeout_pulse), 64'(1));
      chk("tmo_sb_nonempty", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
         chk("tmo_result", {31'h0, pcpi_wr, pcpi_rd}, 64'(sb.pop_front()));
      end
      cp_ready = 2'b01; cp_wr = 2'b01; cp_rd[31:0] = 32'hDEAD;
      @(negedge clk);
      chk("tmo_pulse_end", 64'({timeout_pulse, pcpi_ready}), 64'(0));
      @(negedge clk);
      chk("tmo_late_ignored", 64'({pcpi_ready, pcpi_rd}), 64'(0));
      release_cp();
      end_request("tmo");
`else
      hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (pcpi_ready || timeout_pulse) hit = 1'b1;
      end
      chk("stall_quiet", 64'(hit), 64'(0));
      chk("stall_still_owned", 64'({busy, pcpi_wait, cp_valid}), 64'({1'b1, 1'b1, 2'b01}));
      pcpi_valid = 1'b0;
      @(negedge clk);
      chk("stall_abort", 64'({busy, pcpi_ready, timeout_pulse}), 64'(0));
      release_cp();
`endif

      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pcpi_arbiter.md
# pcpi_arbiter

Shares the picorv32 Pico Co-Processor Interface (PCPI) between up to NUM_CP coprocessors, e.g. the multiply and divide units. Sits between the core's PCPI master port and the coprocessors. It broadcasts each PCPI request and locks onto the first coprocessor that claims it. It returns that coprocessor's result to the core as a single registered response, and releases requests nobody claims so the core's own illegal-instruction timeout can fire.

## Interface
- NUM_CP, 2: number of coprocessor ports (1..4)
- OWNER_W, 1: width of owner index; NUM_CP ≤ 2**OWNER_W
- CLAIM_WIN, 15: cycles a broadcast waits for a claim (must stay below the core's 16-cycle PCPI timeout)
- MAX_BUSY, 64: busy-watchdog limit in cycles (used only with PCPI_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- pcpi_valid  in  1  core request
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand 1
- pcpi_rs2  in  32  operand 2
- pcpi_wr  out  1  result write enable to core
- pcpi_rd  out  32  result to core
- pcpi_wait  out  1  some coprocessor owns the request
- pcpi_ready  out  1  one-cycle completion pulse
- cp_valid  out  NUM_CP  per-coprocessor request
- cp_insn  out  32  shared registered instruction
- cp_rs1  out  32  shared registered operand 1
- cp_rs2  out  32  shared registered operand 2
- cp_wr  in  NUM_CP  per-coprocessor write enable
- cp_rd  in  NUM_CP*32  per-coprocessor result; slice i is [32*i+31:32*i]
- cp_wait  in  NUM_CP  per-coprocessor claim/busy
- cp_ready  in  NUM_CP  per-coprocessor done
- busy  out  1  state ≠ IDLE
- owner  out  OWNER_W  index of current owner
- timeout_pulse  out  1  watchdog fired (tied 0 without macro)

## Operation
- Reset value of every output is 0. Reset clears the state to IDLE and clears all counters.
- **IDLE**: on pcpi_valid=1:
  - register insn/rs1/rs2 into cp_* outputs;
  - set cp_valid to all ones;
  - clear the claim counter;
  - go to BCAST.
- **BCAST**:
  - Claim = any cp_wait[i] or cp_ready[i]. The lowest index wins.
  - Winner: owner←i, cp_valid←one-hot(i), so losers see valid drop the next cycle (abort), and pcpi_wait←1.
  - If the winner's cp_ready=1 in the claim cycle, complete immediately (see OWNED).
  - No claim after CLAIM_WIN cycles: cp_valid←0, go to NOCLAIM. pcpi_wait is never asserted.
  - pcpi_valid dropping (core timeout/trap): cp_valid←0, go to IDLE.
- **OWNED**: wait for cp_ready[owner]. When it arrives:
  - pcpi_ready←1 for one cycle;
  - pcpi_wr←cp_wr[owner], pcpi_rd←cp_rd[owner slice];
  - pcpi_wait←0, cp_valid←0;
  - go to DONE.
  - Non-owner inputs are ignored.
- **DONE**: hold until pcpi_valid=0, then go to IDLE. This prevents re-broadcasting the completed instruction. pcpi_rd keeps its last value; pcpi_wr returns to 0 after the pulse.
- **NOCLAIM**: hold until pcpi_valid=0, then go to IDLE.
- **Simultaneous events**:
  - cp_ready from several ports in BCAST: the lowest index wins; the others are discarded.
  - pcpi_valid falling while OWNED: abort, cp_valid←0, IDLE, no pcpi_ready.

## Timing
- Core request to cp_valid: 1 cycle. Coprocessor claim to pcpi_wait: 1 cycle. cp_ready to pcpi_ready: 1 cycle.
- Minimum request-to-pcpi_ready latency is 2 cycles, for a single-cycle coprocessor that asserts ready at the first cp_valid.
- pcpi_ready is a one-cycle pulse. pcpi_wr/pcpi_rd are valid in that same cycle.
- No back-to-back request is accepted without at least one cycle of pcpi_valid=0.
- Reset is asynchronous and may arrive in any state. Outputs go to 0 immediately; the in-flight request is dropped.

## Configuration
- PCPI_ARB_TIMEOUT_EN defined:
  - In OWNED, a busy counter runs. If cp_ready[owner] has not arrived after MAX_BUSY cycles, the arbiter forces pcpi_ready=1 with pcpi_wr=0 and rd=0, pulses timeout_pulse for 1 cycle, drops cp_valid, and goes to DONE.
  - A late cp_ready from that owner is ignored.
- Undefined: no busy counter. OWNED waits indefinitely, and timeout_pulse is constant 0.

## Test plan
- MUL insn 0x02B50533 (`mul a0,a0,a1`), rs1=0x55, rs2=0x06. cp0 asserts wait at once, then ready after 4 cycles with rd=0x1FE, wr=1. Required: pcpi_wait high; one pcpi_ready pulse with pcpi_wr=1, pcpi_rd=0x000001FE; owner=0; busy drops after pcpi_valid falls.
- cp0 and cp1 both assert wait in the same cycle with rs1=0x0C, rs2=0x10. Required: owner=0, cp_valid=2'b01 the next cycle; cp0 returns 0xC0, so pcpi_rd=0x000000C0.
- Only cp1 claims, then returns 0x12345678. Required: owner=1, pcpi_rd=0x12345678, cp_valid[0] low from the claim+1 cycle.
- No coprocessor claims. Required: cp_valid clears exactly 15 cycles after rising; pcpi_wait and pcpi_ready never assert; IDLE after pcpi_valid falls.
- resetn pulled low while OWNED. Required: all outputs 0 asynchronously, before the next clk edge. After release, a fresh request completes normally.
- With PCPI_ARB_TIMEOUT_EN, cp0 holds wait for 64 cycles without ready. Required: pcpi_ready=1 with pcpi_wr=0, timeout_pulse for 1 cycle. Without the macro: still OWNED at cycle 200, timeout_pulse=0.
